// File: rtl/hls_activity_profiler_if.sv
// Handshake, profiling-control and readout bundle for hls_activity_profiler.
// The master side is the monitored HLS blocks plus the host; the slave side is the profiler.
interface hls_activity_profiler_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    logic [NUM_CH-1:0] ap_start;
    logic [NUM_CH-1:0] ap_done;
    logic [NUM_CH-1:0] ap_continue;
    logic [NUM_CH-1:0] iter_end;
    logic              prof_en;
    logic              clear;
    logic              rd_en;
    logic [3:0]        rd_ch;
    logic [2:0]        rd_sel;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_valid;
    logic [NUM_CH-1:0] active;

    modport master (
        output ap_start, ap_done, ap_continue, iter_end,
        output prof_en, clear, rd_en, rd_ch, rd_sel,
        input  rd_data, rd_valid, active
    );

    modport slave (
        input  ap_start, ap_done, ap_continue, iter_end,
        input  prof_en, clear, rd_en, rd_ch, rd_sel,
        output rd_data, rd_valid, active
    );
endinterface

// File: rtl/hls_activity_profiler.sv
// Per-channel ap_ctrl handshake profiler with saturating counters and a registered readout port.
// Optional macro PROFILER_MAXLAT_EN adds a per-channel maximum-latency register (rd_sel=5).
//
// state     | meaning
// IDLE      | no transaction outstanding on the channel
// RUN       | transaction started, waiting for ap_done
// WAIT_CONT | ap_done seen, held off by ap_continue=0 (back-pressure)
module hls_activity_profiler #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input logic                  clock,
    input logic                  reset,
    hls_activity_profiler_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WAIT_CONT = 2'd2} state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    // Sized to the full rd_ch range so out-of-range channels simply read zero.
    logic [CNT_W-1:0] sel_val [16];
    logic [CNT_W-1:0] rd_data_q;
    logic             rd_valid_q;

    for (genvar c = 0; c < 16; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            state_t           state_q, state_d;
            logic [CNT_W-1:0] acc_q, acc_d, lat_new;
            logic [CNT_W-1:0] txn_q, busy_q, stall_q, iter_q, last_q, sel_c;
            logic             done_evt, busy_evt, stall_evt, complete;

            always_comb begin
                state_d   = state_q;
                acc_d     = acc_q;
                lat_new   = '0;
                done_evt  = 1'b0;
                busy_evt  = 1'b0;
                stall_evt = 1'b0;
                complete  = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (bus.ap_start[c]) begin
                            busy_evt = 1'b1;
                            if (bus.ap_done[c] && bus.ap_continue[c]) begin
                                done_evt = 1'b1;
                                lat_new  = ONE;
                            end else if (bus.ap_done[c]) begin
                                state_d   = WAIT_CONT;
                                stall_evt = 1'b1;
                                acc_d     = ONE;
                            end else begin
                                state_d = RUN;
                                acc_d   = ONE;
                            end
                        end
                    end
                    RUN: begin
                        busy_evt = 1'b1;
                        if (bus.ap_done[c] && bus.ap_continue[c]) begin
                            complete = 1'b1;
                        end else begin
                            acc_d = sat_inc(acc_q);
                            if (bus.ap_done[c]) begin
                                state_d   = WAIT_CONT;
                                stall_evt = 1'b1;
                            end
                        end
                    end
                    WAIT_CONT: begin
                        busy_evt = 1'b1;
                        if (bus.ap_continue[c]) begin
                            complete = 1'b1;
                        end else begin
                            acc_d     = sat_inc(acc_q);
                            stall_evt = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
                // A completion may launch the next transaction in the same cycle.
                if (complete) begin
                    done_evt = 1'b1;
                    lat_new  = sat_inc(acc_q);
                    if (bus.ap_start[c]) begin
                        state_d = RUN;
                        acc_d   = ONE;
                    end else begin
                        state_d = IDLE;
                        acc_d   = '0;
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (reset || bus.clear) begin
                    state_q <= IDLE;
                    acc_q   <= '0;
                    txn_q   <= '0;
                    busy_q  <= '0;
                    stall_q <= '0;
                    iter_q  <= '0;
                    last_q  <= '0;
                end else begin
                    state_q <= state_d;
                    acc_q   <= acc_d;
                    if (bus.prof_en) begin
                        if (done_evt) begin
                            txn_q  <= sat_inc(txn_q);
                            last_q <= lat_new;
                        end
                        if (busy_evt)        busy_q  <= sat_inc(busy_q);
                        if (stall_evt)       stall_q <= sat_inc(stall_q);
                        if (bus.iter_end[c]) iter_q  <= sat_inc(iter_q);
                    end
                end
            end

`ifdef PROFILER_MAXLAT_EN
            logic [CNT_W-1:0] max_q;
            always_ff @(posedge clock) begin
                if (reset || bus.clear)
                    max_q <= '0;
                else if (bus.prof_en && done_evt && (lat_new > max_q))
                    max_q <= lat_new;
            end
`endif

            always_comb begin
                sel_c = '0;
                case (bus.rd_sel)
                    3'd0: sel_c = txn_q;
                    3'd1: sel_c = busy_q;
                    3'd2: sel_c = stall_q;
                    3'd3: sel_c = iter_q;
                    3'd4: sel_c = last_q;
`ifdef PROFILER_MAXLAT_EN
                    3'd5: sel_c = max_q;
`endif
                    default: sel_c = '0;
                endcase
            end

            assign sel_val[c]    = sel_c;
            assign bus.active[c] = (state_q != IDLE);
        end else begin : g_off
            assign sel_val[c] = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= sel_val[bus.rd_ch];
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_hls_activity_profiler.sv
// Directed self-checking bench for hls_activity_profiler: a 32-bit instance for function
// and a CNT_W=8 instance for saturation.
module tb_hls_activity_profiler;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

`ifdef PROFILER_MAXLAT_EN
    localparam bit MAXEN = 1'b1;
`else
    localparam bit MAXEN = 1'b0;
`endif

    hls_activity_profiler_if #(.NUM_CH(4), .CNT_W(32)) bus ();
    hls_activity_profiler_if #(.NUM_CH(4), .CNT_W(8))  bus8 ();

    hls_activity_profiler #(.NUM_CH(4), .CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    hls_activity_profiler #(.NUM_CH(4), .CNT_W(8)) dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (bus8)
    );

    int errors = 0;
    int checks = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input int ch, input int sel, output logic [31:0] data, output logic vld);
        bus.rd_ch  = 4'(ch);
        bus.rd_sel = 3'(sel);
        bus.rd_en  = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        data = bus.rd_data;
        vld  = bus.rd_valid;
    endtask

    task automatic rd8(input int ch, input int sel, output logic [7:0] data, output logic vld);
        bus8.rd_ch  = 4'(ch);
        bus8.rd_sel = 3'(sel);
        bus8.rd_en  = 1'b1;
        tick();
        bus8.rd_en = 1'b0;
        data = bus8.rd_data;
        vld  = bus8.rd_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.ap_start = '0;  bus.ap_done = '0;  bus.ap_continue = '1; bus.iter_end = '0;
        bus.prof_en = 1'b1; bus.clear = 1'b0;  bus.rd_en = 1'b0;  bus.rd_ch = '0; bus.rd_sel = '0;
        bus8.ap_start = '0; bus8.ap_done = '0; bus8.ap_continue = '1; bus8.iter_end = '0;
        bus8.prof_en = 1'b1; bus8.clear = 1'b0; bus8.rd_en = 1'b0; bus8.rd_ch = '0; bus8.rd_sel = '0;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (bus.rd_data !== 32'd0 || bus.rd_valid !== 1'b0 || bus.active !== 4'b0000) begin
            errors++;
            $display("FAIL reset: rd_data=%0d rd_valid=%b active=%b, want 0 0 0000",
                     bus.rd_data, bus.rd_valid, bus.active);
        end
        checks++;
        if (bus8.rd_data !== 8'd0 || bus8.rd_valid !== 1'b0 || bus8.active !== 4'b0000) begin
            errors++;
            $display("FAIL reset8: rd_data=%0d rd_valid=%b active=%b, want 0 0 0000",
                     bus8.rd_data, bus8.rd_valid, bus8.active);
        end
    endtask

    // Start at edge 0, done+continue at edge 9: latency 10, 10 transaction cycles.
    task automatic test_single();
        logic [31:0] d;
        logic        v;
        logic [31:0] exp_v [6];
        exp_v[0] = 1; exp_v[1] = 10; exp_v[2] = 0; exp_v[3] = 0; exp_v[4] = 10;
        exp_v[5] = MAXEN ? 32'd10 : 32'd0;
        bus.ap_start[0] = 1'b1;
        tick();
        bus.ap_start[0] = 1'b0;
        checks++;
        if (bus.active !== 4'b0001) begin
            errors++;
            $display("FAIL single_active_on: got %b, want 0001", bus.active);
        end
        repeat (8) tick();
        checks++;
        if (bus.active[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_active_hold: got %b, want 1", bus.active[0]);
        end
        bus.ap_done[0] = 1'b1;
        tick();
        bus.ap_done[0] = 1'b0;
        checks++;
        if (bus.active !== 4'b0000) begin
            errors++;
            $display("FAIL single_active_off: got %b, want 0000", bus.active);
        end
        for (int s = 0; s < 6; s++) begin
            rd(0, s, d, v);
            checks++;
            if (d !== exp_v[s] || v !== 1'b1) begin
                errors++;
                $display("FAIL single_sel%0d: got %0d valid=%b, want %0d valid=1", s, d, v, exp_v[s]);
            end
        end
    endtask

    // Done at edge 5 with continue low through edge 7, released at edge 8; a stray start is ignored.
    task automatic test_stall();
        logic [31:0] d;
        logic        v;
        logic [31:0] exp_v [6];
        exp_v[0] = 1; exp_v[1] = 9; exp_v[2] = 3; exp_v[3] = 0; exp_v[4] = 9;
        exp_v[5] = MAXEN ? 32'd9 : 32'd0;
        bus.ap_start[1] = 1'b1;
        tick();
        bus.ap_start[1] = 1'b0;
        tick();
        bus.ap_start[1] = 1'b1;
        tick();
        bus.ap_start[1] = 1'b0;
        repeat (2) tick();
        bus.ap_done[1] = 1'b1;
        bus.ap_continue[1] = 1'b0;
        tick();
        bus.ap_done[1] = 1'b0;
        repeat (2) tick();
        bus.ap_continue[1] = 1'b1;
        tick();
        for (int s = 0; s < 6; s++) begin
            rd(1, s, d, v);
            checks++;
            if (d !== exp_v[s] || v !== 1'b1) begin
                errors++;
                $display("FAIL stall_sel%0d: got %0d valid=%b, want %0d valid=1", s, d, v, exp_v[s]);
            end
        end
    endtask

    // Three latency-4 transactions, each new start the cycle after completion, then 12 iter pulses.
    task automatic test_back_to_back();
        logic [31:0] d;
        logic        v;
        logic [31:0] exp_v [6];
        exp_v[0] = 3; exp_v[1] = 12; exp_v[2] = 0; exp_v[3] = 12; exp_v[4] = 4;
        exp_v[5] = MAXEN ? 32'd4 : 32'd0;
        for (int t = 0; t < 3; t++) begin
            bus.ap_start[2] = 1'b1;
            tick();
            bus.ap_start[2] = 1'b0;
            repeat (2) tick();
            bus.ap_done[2] = 1'b1;
            tick();
            bus.ap_done[2] = 1'b0;
        end
        for (int i = 0; i < 12; i++) begin
            bus.iter_end[2] = 1'b1;
            tick();
            bus.iter_end[2] = 1'b0;
            tick();
        end
        for (int s = 0; s < 6; s++) begin
            rd(2, s, d, v);
            checks++;
            if (d !== exp_v[s] || v !== 1'b1) begin
                errors++;
                $display("FAIL b2b_sel%0d: got %0d valid=%b, want %0d valid=1", s, d, v, exp_v[s]);
            end
        end
    endtask

    // Completion and restart in the same cycle (lat 3 then 4), then a zero-wait transaction.
    task automatic test_chain();
        logic [31:0] d;
        logic        v;
        logic [31:0] exp_v [6];
        exp_v[0] = 2; exp_v[1] = 6; exp_v[2] = 0; exp_v[3] = 0; exp_v[4] = 4;
        exp_v[5] = MAXEN ? 32'd4 : 32'd0;
        bus.ap_start[3] = 1'b1;
        tick();
        bus.ap_start[3] = 1'b0;
        tick();
        bus.ap_start[3] = 1'b1;
        bus.ap_done[3] = 1'b1;
        tick();
        bus.ap_start[3] = 1'b0;
        bus.ap_done[3] = 1'b0;
        checks++;
        if (bus.active[3] !== 1'b1) begin
            errors++;
            $display("FAIL chain_active: got %b, want 1", bus.active[3]);
        end
        repeat (2) tick();
        bus.ap_done[3] = 1'b1;
        tick();
        bus.ap_done[3] = 1'b0;
        for (int s = 0; s < 6; s++) begin
            rd(3, s, d, v);
            checks++;
            if (d !== exp_v[s] || v !== 1'b1) begin
                errors++;
                $display("FAIL chain_sel%0d: got %0d valid=%b, want %0d valid=1", s, d, v, exp_v[s]);
            end
        end
        bus.ap_start[3] = 1'b1;
        bus.ap_done[3] = 1'b1;
        tick();
        bus.ap_start[3] = 1'b0;
        bus.ap_done[3] = 1'b0;
        checks++;
        if (bus.active[3] !== 1'b0) begin
            errors++;
            $display("FAIL zw_active: got %b, want 0", bus.active[3]);
        end
        rd(3, 0, d, v);
        checks++;
        if (d !== 32'd3) begin
            errors++;
            $display("FAIL zw_txn: got %0d, want 3", d);
        end
        rd(3, 4, d, v);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL zw_last_lat: got %0d, want 1", d);
        end
        rd(3, 5, d, v);
        checks++;
        if (d !== (MAXEN ? 32'd4 : 32'd0)) begin
            errors++;
            $display("FAIL zw_max_lat: got %0d, want %0d", d, MAXEN ? 4 : 0);
        end
    endtask

    // Start with profiling frozen, resume mid-transaction: latency still measured from start.
    task automatic test_prof_en();
        logic [31:0] d;
        logic        v;
        logic [31:0] exp_v [6];
        exp_v[0] = 2; exp_v[1] = 11; exp_v[2] = 3; exp_v[3] = 0; exp_v[4] = 5;
        exp_v[5] = MAXEN ? 32'd9 : 32'd0;
        bus.prof_en = 1'b0;
        bus.ap_start[1] = 1'b1;
        tick();
        bus.ap_start[1] = 1'b0;
        bus.iter_end[1] = 1'b1;
        tick();
        bus.iter_end[1] = 1'b0;
        tick();
        bus.prof_en = 1'b1;
        tick();
        bus.ap_done[1] = 1'b1;
        tick();
        bus.ap_done[1] = 1'b0;
        for (int s = 0; s < 6; s++) begin
            rd(1, s, d, v);
            checks++;
            if (d !== exp_v[s] || v !== 1'b1) begin
                errors++;
                $display("FAIL prof_en_sel%0d: got %0d valid=%b, want %0d valid=1", s, d, v, exp_v[s]);
            end
        end
    endtask

    task automatic test_read_port();
        logic [31:0] d;
        logic        v;
        rd(5, 0, d, v);
        checks++;
        if (d !== 32'd0 || v !== 1'b1) begin
            errors++;
            $display("FAIL rd_ch5: got %0d valid=%b, want 0 valid=1", d, v);
        end
        tick();
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_drop: got %b, want 0", bus.rd_valid);
        end
        rd(1, 6, d, v);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rd_sel6: got %0d, want 0", d);
        end
        // rd_en held over two edges with the select changing in between.
        bus.rd_ch = 4'd0;
        bus.rd_sel = 3'd0;
        bus.rd_en = 1'b1;
        tick();
        checks++;
        if (bus.rd_data !== 32'd1 || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL rd_burst0: got %0d valid=%b, want 1 valid=1", bus.rd_data, bus.rd_valid);
        end
        bus.rd_sel = 3'd1;
        tick();
        bus.rd_en = 1'b0;
        checks++;
        if (bus.rd_data !== 32'd10 || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL rd_burst1: got %0d valid=%b, want 10 valid=1", bus.rd_data, bus.rd_valid);
        end
    endtask

    task automatic test_clear();
        logic [31:0] d;
        logic        v;
        bus.ap_start[0] = 1'b1;
        tick();
        bus.ap_start[0] = 1'b0;
        repeat (3) tick();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        checks++;
        if (bus.active !== 4'b0000) begin
            errors++;
            $display("FAIL clear_active: got %b, want 0000", bus.active);
        end
        bus.ap_done[0] = 1'b1;
        tick();
        bus.ap_done[0] = 1'b0;
        rd(0, 0, d, v);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL clear_txn: got %0d, want 0", d);
        end
        rd(0, 1, d, v);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL clear_busy: got %0d, want 0", d);
        end
        rd(1, 4, d, v);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL clear_last_lat_ch1: got %0d, want 0", d);
        end
    endtask

    task automatic test_saturate();
        logic [7:0] d;
        logic       v;
        bus8.ap_start[3] = 1'b1;
        tick();
        bus8.ap_start[3] = 1'b0;
        repeat (300) tick();
        rd8(3, 1, d, v);
        checks++;
        if (d !== 8'd255 || v !== 1'b1) begin
            errors++;
            $display("FAIL sat_busy: got %0d valid=%b, want 255 valid=1", d, v);
        end
        bus8.ap_done[3] = 1'b1;
        tick();
        bus8.ap_done[3] = 1'b0;
        rd8(3, 4, d, v);
        checks++;
        if (d !== 8'd255) begin
            errors++;
            $display("FAIL sat_last_lat: got %0d, want 255", d);
        end
        rd8(3, 0, d, v);
        checks++;
        if (d !== 8'd1) begin
            errors++;
            $display("FAIL sat_txn: got %0d, want 1", d);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_chain();
        test_prof_en();
        test_read_port();
        test_clear();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
